// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state encoding and serial line levels for the UART transmitter
package uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic IDLE_LINE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shadow data register and bit counter that present the next data bit to send
// ports: clk, rst_n (sync active-low), load (capture data), ser_en (high while in DATA),
//        data (word to capture), ser_bit (bit to drive on the next edge), ser_done (last data bit on the line)
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  ser_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  ser_done
);
  logic [DATA_WIDTH-1:0] shadow;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  nxt;
  assign ser_done = cnt == CNT_WIDTH'(DATA_WIDTH - 1);
  assign nxt      = ser_done ? CNT_WIDTH'(0) : cnt + CNT_WIDTH'(1);
  // outside DATA the counter sits at 0, so the START exit edge picks up bit 0
  assign ser_bit  = shadow[ser_en ? nxt : CNT_WIDTH'(0)];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
      cnt    <= '0;
    end else begin
      if (load) shadow <= data;
      cnt <= ser_en ? nxt : '0;
    end
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit FSM framing start, LSB-first data, optional parity and stop bits
// ports: CLK (baud clock), RST (sync active-low), P_DATA/Data_Valid/PAR_EN/par_bit (word in),
//        TX_OUT (serial line, idle high), busy (frame in progress)
// option: define UART_TX_TWO_STOP_EN for two stop bits
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy
);
  state_t state;
  logic   shadow_par;
  logic   shadow_pen;
  logic   ser_bit;
  logic   ser_done;
`ifdef UART_TX_TWO_STOP_EN
  logic   stop_cnt;
`endif
  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (state == IDLE && Data_Valid),
    .ser_en   (state == DATA),
    .data     (P_DATA),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      TX_OUT     <= IDLE_LINE;
      busy       <= 1'b0;
      shadow_par <= 1'b0;
      shadow_pen <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state      <= Data_Valid ? START : IDLE;
          TX_OUT     <= Data_Valid ? START_BIT : IDLE_LINE;
          busy       <= Data_Valid;
          shadow_par <= Data_Valid ? par_bit : shadow_par;
          shadow_pen <= Data_Valid ? PAR_EN : shadow_pen;
        end
        START: begin
          state  <= DATA;
          TX_OUT <= ser_bit;
        end
        DATA: begin
          state  <= !ser_done ? DATA : shadow_pen ? PARITY : STOP;
          TX_OUT <= !ser_done ? ser_bit : shadow_pen ? shadow_par : STOP_BIT;
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
        end
        STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          // first STOP cycle holds the line high for one more bit
          state    <= stop_cnt ? IDLE : STOP;
          busy     <= !stop_cnt;
          stop_cnt <= !stop_cnt;
`else
          state    <= IDLE;
          busy     <= 1'b0;
`endif
          TX_OUT   <= IDLE_LINE;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= IDLE_LINE;
          busy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized and directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         data_valid = 1'b0;
  logic         par_en = 1'b0;
  logic         par_bit = 1'b0;
  logic         tx_out;
  logic         busy;
  int           n_chk = 0;
  int           n_fail = 0;

  uart_tx_ctrl #(.DATA_WIDTH(W), .CNT_WIDTH(3)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .PAR_EN     (par_en),
    .par_bit    (par_bit),
    .TX_OUT     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_idle(input string name);
    n_chk += 2;
    if (tx_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle tx: got %b expected 1", name, tx_out);
    end
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle busy: got %b expected 0", name, busy);
    end
  endtask

  // Called at a negedge; strobes the word now and checks every bit of the frame
  // against one built from the framing rules. inject >= 0 pulses Data_Valid with
  // an all-ones word at that frame position, which must be ignored.
  task automatic run_frame(input logic [W-1:0] d, input logic pen, input logic pb,
                           input int inject, input string name);
    logic exp[$];
    exp.push_back(1'b0);
    for (int i = 0; i < W; i++) exp.push_back(d[i]);
    if (pen) exp.push_back(pb);
    exp.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
    exp.push_back(1'b1);
`endif
    p_data = d;
    par_en = pen;
    par_bit = pb;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    for (int i = 0; i < exp.size(); i++) begin
      n_chk += 2;
      if (tx_out !== exp[i]) begin
        n_fail++;
        $display("FAIL %s bit%0d tx: got %b expected %b", name, i, tx_out, exp[i]);
      end
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s bit%0d busy: got %b expected 1", name, i, busy);
      end
      p_data = W'($urandom);
      par_en = 1'($urandom);
      par_bit = 1'($urandom);
      data_valid = (i == inject);
      if (i == inject) p_data = '1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    check_idle(name);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
  endtask

  task automatic test_parity();
    run_frame(8'hA5, 1'b1, 1'b0, -1, "even_parity");
    run_frame(8'hA5, 1'b1, 1'b1, -1, "odd_parity");
    run_frame(8'h3C, 1'b0, 1'b0, -1, "no_parity");
    run_frame(8'h00, 1'b0, 1'b0, -1, "zero_word");
  endtask

  task automatic test_ignore_busy();
    @(negedge clk);
    run_frame(8'hA5, 1'b1, 1'b0, 4, "ignore_busy");
    run_frame(8'hFF, 1'b0, 1'b0, -1, "back_to_back");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    p_data = 8'hA5;
    par_en = 1'b1;
    par_bit = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset_hold");
    run_frame(8'h5A, 1'b1, 1'b0, -1, "post_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_idle("rand_gap");
      end
      run_frame(W'($urandom), 1'($urandom), 1'($urandom), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_ignore_busy();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
